// File: rtl/alignment_cigar_encoder.sv
// Walks one latched smith_waterman alignment from its start slot down to slot 0 and
// emits run-length CIGAR ops (M/X/I/D) on a valid/ready stream with match/edit totals.
module alignment_cigar_encoder #(
    parameter int unsigned ALIGN_LEN  = 25,
    parameter int unsigned BASE_WIDTH = 2,
    parameter int unsigned RUN_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ALIGN_LEN*BASE_WIDTH-1:0] aligned_ref_seq,
    input  logic [ALIGN_LEN*BASE_WIDTH-1:0] aligned_query_seq,
    input  logic [ALIGN_LEN-1:0]          ref_gap_mask,
    input  logic [ALIGN_LEN-1:0]          query_gap_mask,
    input  logic [7:0]                    alignment_length,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    out_op,
    output logic [RUN_WIDTH-1:0]          out_run_len,
    output logic                          out_last,
    output logic [7:0]                    match_count,
    output logic [7:0]                    edit_count,
    output logic                          done,
    output logic                          err_both_gap
);

    localparam int unsigned IdxW = (ALIGN_LEN > 1) ? $clog2(ALIGN_LEN) : 1;
    localparam logic [7:0] AlignLenB = 8'(ALIGN_LEN);
    localparam logic [RUN_WIDTH-1:0] RunMax = '1;
    localparam logic [RUN_WIDTH-1:0] RunOne = RUN_WIDTH'(1);

    localparam logic [1:0] OpM = 2'd0;
    localparam logic [1:0] OpX = 2'd1;
    localparam logic [1:0] OpI = 2'd2;
    localparam logic [1:0] OpD = 2'd3;

    typedef enum logic [1:0] {StIdle, StScan, StEmit} state_e;

    state_e                          state_q;
    logic [ALIGN_LEN*BASE_WIDTH-1:0] ref_q, qry_q;
    logic [ALIGN_LEN-1:0]            rgap_q, qgap_q;
    logic [IdxW-1:0]                 idx_q;
    logic [1:0]                      cur_op_q;
    logic [RUN_WIDTH-1:0]            cur_run_q;
    logic                            out_valid_q, out_last_q, done_q, err_q;
    logic [1:0]                      out_op_q;
    logic [RUN_WIDTH-1:0]            out_run_len_q;
    logic [7:0]                      match_q, edit_q;

    logic [BASE_WIDTH-1:0] ref_base, qry_base;
    logic                  skip, extend, boundary, idx_zero;
    logic [1:0]            slot_op;
    logic [RUN_WIDTH-1:0]  run_next;
    logic [7:0]            leff;

    always_comb begin
        leff     = (alignment_length > AlignLenB) ? AlignLenB : alignment_length;
        ref_base = ref_q[idx_q*BASE_WIDTH +: BASE_WIDTH];
        qry_base = qry_q[idx_q*BASE_WIDTH +: BASE_WIDTH];
        skip     = rgap_q[idx_q] & qgap_q[idx_q];
        // Bases on a gapped side are meaningless, so gaps decide before the base compare.
        if (qgap_q[idx_q]) begin
            slot_op = OpD;
        end else if (rgap_q[idx_q]) begin
            slot_op = OpI;
        end else if (ref_base == qry_base) begin
            slot_op = OpM;
        end else begin
            slot_op = OpX;
        end
        extend   = (cur_run_q == '0) || ((slot_op == cur_op_q) && (cur_run_q != RunMax));
        run_next = (cur_run_q == '0) ? RunOne : cur_run_q + 1'b1;
        boundary = !skip && !extend;
        idx_zero = (idx_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ref_q         <= '0;
            qry_q         <= '0;
            rgap_q        <= '0;
            qgap_q        <= '0;
            idx_q         <= '0;
            cur_op_q      <= OpM;
            cur_run_q     <= '0;
            out_valid_q   <= 1'b0;
            out_op_q      <= OpM;
            out_run_len_q <= '0;
            out_last_q    <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            match_q       <= '0;
            edit_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        ref_q     <= aligned_ref_seq;
                        qry_q     <= aligned_query_seq;
                        rgap_q    <= ref_gap_mask;
                        qgap_q    <= query_gap_mask;
                        idx_q     <= IdxW'(leff - 8'd1);
                        cur_run_q <= '0;
                        match_q   <= '0;
                        edit_q    <= '0;
                        err_q     <= 1'b0;
                        if (leff == 8'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StScan;
                        end
                    end
                end
                StScan: begin
                    if (skip) begin
                        err_q <= 1'b1;
                        if (!idx_zero) begin
                            idx_q <= idx_q - 1'b1;
                        end else if (cur_run_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            out_valid_q   <= 1'b1;
                            out_op_q      <= cur_op_q;
                            out_run_len_q <= cur_run_q;
                            out_last_q    <= 1'b1;
                            state_q       <= StEmit;
                        end
                    end else if (boundary) begin
                        // Slot stays pending; it is reclassified after the op drains.
                        out_valid_q   <= 1'b1;
                        out_op_q      <= cur_op_q;
                        out_run_len_q <= cur_run_q;
                        out_last_q    <= 1'b0;
                        state_q       <= StEmit;
                    end else begin
                        cur_op_q  <= slot_op;
                        cur_run_q <= run_next;
                        if (slot_op == OpM) begin
                            if (match_q != 8'hFF) match_q <= match_q + 8'd1;
                        end else begin
                            if (edit_q != 8'hFF) edit_q <= edit_q + 8'd1;
                        end
                        if (idx_zero) begin
                            out_valid_q   <= 1'b1;
                            out_op_q      <= slot_op;
                            out_run_len_q <= run_next;
                            out_last_q    <= 1'b1;
                            state_q       <= StEmit;
                        end else begin
                            idx_q <= idx_q - 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        cur_run_q   <= '0;
                        if (out_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StScan;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = out_valid_q;
    assign out_op       = out_op_q;
    assign out_run_len  = out_run_len_q;
    assign out_last     = out_last_q;
    assign match_count  = match_q;
    assign edit_count   = edit_q;
    assign done         = done_q;
    assign err_both_gap = err_q;

endmodule

// File: tb/tb_alignment_cigar_encoder.sv
// Directed bench for alignment_cigar_encoder: instance a uses RUN_WIDTH=8, instance b RUN_WIDTH=2.
module tb_alignment_cigar_encoder;

    localparam int AL = 25;
    localparam int BW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic              out_ready_a = 1'b1, out_ready_b = 1'b1;
    logic [AL*BW-1:0]  ref_seq = '0, qry_seq = '0;
    logic [AL-1:0]     rgap = '0, qgap = '0;
    logic [7:0]        alen = '0;

    logic       a_in_ready, a_out_valid, a_out_last, a_done, a_err;
    logic [1:0] a_out_op;
    logic [7:0] a_out_run_len, a_match, a_edit;
    logic       b_in_ready, b_out_valid, b_out_last, b_done, b_err;
    logic [1:0] b_out_op, b_out_run_len;
    logic [7:0] b_match, b_edit;

    alignment_cigar_encoder #(.ALIGN_LEN(AL), .BASE_WIDTH(BW), .RUN_WIDTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(a_in_ready),
        .aligned_ref_seq(ref_seq), .aligned_query_seq(qry_seq),
        .ref_gap_mask(rgap), .query_gap_mask(qgap), .alignment_length(alen),
        .out_valid(a_out_valid), .out_ready(out_ready_a), .out_op(a_out_op),
        .out_run_len(a_out_run_len), .out_last(a_out_last), .match_count(a_match),
        .edit_count(a_edit), .done(a_done), .err_both_gap(a_err)
    );

    alignment_cigar_encoder #(.ALIGN_LEN(AL), .BASE_WIDTH(BW), .RUN_WIDTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(b_in_ready),
        .aligned_ref_seq(ref_seq), .aligned_query_seq(qry_seq),
        .ref_gap_mask(rgap), .query_gap_mask(qgap), .alignment_length(alen),
        .out_valid(b_out_valid), .out_ready(out_ready_b), .out_op(b_out_op),
        .out_run_len(b_out_run_len), .out_last(b_out_last), .match_count(b_match),
        .edit_count(b_edit), .done(b_done), .err_both_gap(b_err)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    int valid_a = 0, done_cnt_a = 0, hs_cyc_a = 0, done_cyc_a = 0, done_cnt_b = 0;
    logic [10:0] ops_a[$];
    logic [10:0] ops_b[$];
    int seq[0:39];  // start-to-end column kinds: 0 M, 1 X, 2 I, 3 D, 4 both gaps

    always @(posedge clk) cyc++;

    // Record accepted ops and done pulses on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_out_valid) valid_a++;
            if (a_out_valid && out_ready_a) begin
                ops_a.push_back({a_out_op, a_out_run_len, a_out_last});
                hs_cyc_a = cyc;
            end
            if (a_done) begin
                done_cnt_a++;
                done_cyc_a = cyc;
            end
            if (b_out_valid && out_ready_b) ops_b.push_back({b_out_op, 6'b0, b_out_run_len, b_out_last});
            if (b_done) done_cnt_b++;
        end
    end

    function automatic logic [10:0] pk(input logic [1:0] op, input logic [7:0] len, input logic last);
        return {op, len, last};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bus(input int n, input int l);
        ref_seq = '0; qry_seq = '0; rgap = '0; qgap = '0;
        alen = 8'(l);
        for (int p = 0; p < n; p++) begin
            int s;
            logic [1:0] r;
            s = n - 1 - p;
            r = 2'(p);
            case (seq[p])
                0: begin ref_seq[s*BW +: BW] = r; qry_seq[s*BW +: BW] = r; end
                1: begin ref_seq[s*BW +: BW] = r; qry_seq[s*BW +: BW] = r ^ 2'd1; end
                2: begin rgap[s] = 1'b1; ref_seq[s*BW +: BW] = r ^ 2'd2; qry_seq[s*BW +: BW] = r; end
                3: begin qgap[s] = 1'b1; ref_seq[s*BW +: BW] = r; qry_seq[s*BW +: BW] = r ^ 2'd3; end
                default: begin rgap[s] = 1'b1; qgap[s] = 1'b1; end
            endcase
        end
    endtask

    task automatic go_a();
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({a_in_ready, a_out_valid, a_out_op, a_out_run_len, a_out_last, a_done, a_err,
             a_match, a_edit} !== {1'b1, 30'b0}) begin
            failures++;
            $display("FAIL reset_a: got %h want %h", {a_in_ready, a_out_valid, a_out_op,
                     a_out_run_len, a_out_last, a_done, a_err, a_match, a_edit}, {1'b1, 30'b0});
        end
        checks++;
        if ({b_in_ready, b_out_valid, b_out_op, b_out_run_len, b_out_last, b_done, b_err}
            !== {1'b1, 8'b0}) begin
            failures++;
            $display("FAIL reset_b: got %b want %b", {b_in_ready, b_out_valid, b_out_op,
                     b_out_run_len, b_out_last, b_done, b_err}, {1'b1, 8'b0});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_all_match();
        int d0, n;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        load_bus(4, 4);
        ops_a.delete();
        d0 = done_cnt_a;
        go_a();
        n = 0;
        while (done_cnt_a == d0 && n < 100) begin tick(); n++; end
        checks++;
        if (done_cnt_a == d0) begin failures++; $display("FAIL all_match_done: got 0 pulses want 1"); end
        checks++;
        if (ops_a.size() != 1 || ops_a[0] !== pk(2'd0, 8'd4, 1'b1)) begin
            failures++;
            $display("FAIL all_match_ops: got %0d ops first %h want 1 op %h", ops_a.size(),
                     ops_a.size() > 0 ? ops_a[0] : 11'h0, pk(2'd0, 8'd4, 1'b1));
        end
        checks++;
        if (a_match !== 8'd4 || a_edit !== 8'd0) begin
            failures++;
            $display("FAIL all_match_counts: got m=%0d e=%0d want m=4 e=0", a_match, a_edit);
        end
        checks++;
        if (done_cyc_a != hs_cyc_a + 1) begin
            failures++;
            $display("FAIL all_match_done_timing: got done at +%0d want +1", done_cyc_a - hs_cyc_a);
        end
    endtask

    task automatic test_mixed();
        int d0, n;
        logic [10:0] exp_ops[4];
        seq[0] = 0; seq[1] = 0; seq[2] = 1; seq[3] = 3; seq[4] = 3; seq[5] = 0;
        load_bus(6, 6);
        exp_ops[0] = pk(2'd0, 8'd2, 1'b0);
        exp_ops[1] = pk(2'd1, 8'd1, 1'b0);
        exp_ops[2] = pk(2'd3, 8'd2, 1'b0);
        exp_ops[3] = pk(2'd0, 8'd1, 1'b1);
        ops_a.delete();
        d0 = done_cnt_a;
        go_a();
        n = 0;
        while (done_cnt_a == d0 && n < 100) begin tick(); n++; end
        checks++;
        if (ops_a.size() != 4) begin
            failures++;
            $display("FAIL mixed_count: got %0d ops want 4", ops_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ops_a[i] !== exp_ops[i]) begin
                    failures++;
                    $display("FAIL mixed_op%0d: got %h want %h", i, ops_a[i], exp_ops[i]);
                end
            end
        end
        checks++;
        if (a_match !== 8'd3 || a_edit !== 8'd3) begin
            failures++;
            $display("FAIL mixed_counts: got m=%0d e=%0d want m=3 e=3", a_match, a_edit);
        end
    endtask

    task automatic test_backpressure();
        int d0, n;
        logic [10:0] exp_ops[3];
        seq[0] = 2; seq[1] = 2; seq[2] = 0; seq[3] = 1;
        load_bus(4, 4);
        exp_ops[0] = pk(2'd2, 8'd2, 1'b0);
        exp_ops[1] = pk(2'd0, 8'd1, 1'b0);
        exp_ops[2] = pk(2'd1, 8'd1, 1'b1);
        ops_a.delete();
        out_ready_a = 1'b0;
        d0 = done_cnt_a;
        go_a();
        n = 0;
        while (!a_out_valid && n < 20) begin tick(); n++; end
        checks++;
        if ({a_out_valid, a_out_op, a_out_run_len, a_out_last} !== {1'b1, exp_ops[0]}) begin
            failures++;
            $display("FAIL bp_first: got v=%b %h want v=1 %h", a_out_valid,
                     pk(a_out_op, a_out_run_len, a_out_last), exp_ops[0]);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({a_out_valid, a_out_op, a_out_run_len, a_out_last} !== {1'b1, exp_ops[0]}) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b %h want v=1 %h", i, a_out_valid,
                         pk(a_out_op, a_out_run_len, a_out_last), exp_ops[0]);
            end
        end
        out_ready_a = 1'b1;
        n = 0;
        while (done_cnt_a == d0 && n < 100) begin tick(); n++; end
        checks++;
        if (ops_a.size() != 3) begin
            failures++;
            $display("FAIL bp_count: got %0d ops want 3", ops_a.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ops_a[i] !== exp_ops[i]) begin
                    failures++;
                    $display("FAIL bp_op%0d: got %h want %h", i, ops_a[i], exp_ops[i]);
                end
            end
        end
        checks++;
        if (a_match !== 8'd1 || a_edit !== 8'd3) begin
            failures++;
            $display("FAIL bp_counts: got m=%0d e=%0d want m=1 e=3", a_match, a_edit);
        end
    endtask

    task automatic test_run_max();
        int d0, n;
        for (int i = 0; i < 5; i++) seq[i] = 0;
        load_bus(5, 5);
        ops_b.delete();
        d0 = done_cnt_b;
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        n = 0;
        while (done_cnt_b == d0 && n < 100) begin tick(); n++; end
        checks++;
        if (ops_b.size() != 2 || ops_b[0] !== pk(2'd0, 8'd3, 1'b0) || ops_b[1] !== pk(2'd0, 8'd2, 1'b1)) begin
            failures++;
            $display("FAIL run_max_ops: got %0d ops %h %h want 2 ops %h %h", ops_b.size(),
                     ops_b.size() > 0 ? ops_b[0] : 11'h0, ops_b.size() > 1 ? ops_b[1] : 11'h0,
                     pk(2'd0, 8'd3, 1'b0), pk(2'd0, 8'd2, 1'b1));
        end
        checks++;
        if (b_match !== 8'd5 || b_edit !== 8'd0) begin
            failures++;
            $display("FAIL run_max_counts: got m=%0d e=%0d want m=5 e=0", b_match, b_edit);
        end
    endtask

    task automatic test_lengths();
        int d0, n, v0;
        load_bus(0, 0);
        ops_a.delete();
        d0 = done_cnt_a;
        v0 = valid_a;
        go_a();
        n = 0;
        while (done_cnt_a == d0 && n < 10) begin tick(); n++; end
        checks++;
        if (done_cnt_a != d0 + 1 || ops_a.size() != 0 || valid_a != v0) begin
            failures++;
            $display("FAIL zero_len: got done=%0d ops=%0d valid_cycles=%0d want 1 0 0",
                     done_cnt_a - d0, ops_a.size(), valid_a - v0);
        end
        checks++;
        if (a_done !== 1'b0 || a_match !== 8'd0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_after: got done=%b m=%0d rdy=%b want 0 0 1", a_done, a_match,
                     a_in_ready);
        end
        for (int i = 0; i < 25; i++) seq[i] = 0;
        load_bus(25, 40);
        ops_a.delete();
        d0 = done_cnt_a;
        go_a();
        n = 0;
        while (done_cnt_a == d0 && n < 100) begin tick(); n++; end
        checks++;
        if (ops_a.size() != 1 || ops_a[0] !== pk(2'd0, 8'd25, 1'b1) || a_match !== 8'd25) begin
            failures++;
            $display("FAIL clamp: got %0d ops %h m=%0d want 1 op %h m=25", ops_a.size(),
                     ops_a.size() > 0 ? ops_a[0] : 11'h0, a_match, pk(2'd0, 8'd25, 1'b1));
        end
    endtask

    task automatic test_both_gap();
        int d0, n;
        seq[0] = 0; seq[1] = 0; seq[2] = 4; seq[3] = 0;
        load_bus(4, 4);
        ops_a.delete();
        d0 = done_cnt_a;
        go_a();
        n = 0;
        while (done_cnt_a == d0 && n < 100) begin tick(); n++; end
        checks++;
        if (ops_a.size() != 1 || ops_a[0] !== pk(2'd0, 8'd3, 1'b1) || a_err !== 1'b1
            || a_match !== 8'd3 || a_edit !== 8'd0) begin
            failures++;
            $display("FAIL gap_mid: got %0d ops %h err=%b m=%0d e=%0d want 1 op %h err=1 m=3 e=0",
                     ops_a.size(), ops_a.size() > 0 ? ops_a[0] : 11'h0, a_err, a_match, a_edit,
                     pk(2'd0, 8'd3, 1'b1));
        end
        seq[0] = 0; seq[1] = 1; seq[2] = 4;
        load_bus(3, 3);
        ops_a.delete();
        d0 = done_cnt_a;
        go_a();
        n = 0;
        while (done_cnt_a == d0 && n < 100) begin tick(); n++; end
        checks++;
        if (ops_a.size() != 2 || ops_a[0] !== pk(2'd0, 8'd1, 1'b0) || ops_a[1] !== pk(2'd1, 8'd1, 1'b1)
            || a_err !== 1'b1) begin
            failures++;
            $display("FAIL gap_last: got %0d ops %h %h err=%b want 2 ops %h %h err=1", ops_a.size(),
                     ops_a.size() > 0 ? ops_a[0] : 11'h0, ops_a.size() > 1 ? ops_a[1] : 11'h0,
                     a_err, pk(2'd0, 8'd1, 1'b0), pk(2'd1, 8'd1, 1'b1));
        end
        seq[0] = 4;
        load_bus(1, 1);
        ops_a.delete();
        d0 = done_cnt_a;
        go_a();
        n = 0;
        while (done_cnt_a == d0 && n < 20) begin tick(); n++; end
        checks++;
        if (done_cnt_a != d0 + 1 || ops_a.size() != 0 || a_err !== 1'b1) begin
            failures++;
            $display("FAIL gap_only: got done=%0d ops=%0d err=%b want 1 0 1", done_cnt_a - d0,
                     ops_a.size(), a_err);
        end
        seq[0] = 0;
        load_bus(1, 1);
        ops_a.delete();
        d0 = done_cnt_a;
        go_a();
        n = 0;
        while (done_cnt_a == d0 && n < 20) begin tick(); n++; end
        checks++;
        if (ops_a.size() != 1 || ops_a[0] !== pk(2'd0, 8'd1, 1'b1) || a_err !== 1'b0) begin
            failures++;
            $display("FAIL gap_clear: got %0d ops err=%b want 1 op err=0", ops_a.size(), a_err);
        end
    endtask

    task automatic test_reset_mid();
        int v0, o0;
        for (int i = 0; i < 25; i++) seq[i] = 0;
        load_bus(25, 25);
        ops_a.delete();
        go_a();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({a_in_ready, a_out_valid, a_out_op, a_out_run_len, a_out_last, a_done, a_err,
             a_match, a_edit} !== {1'b1, 30'b0}) begin
            failures++;
            $display("FAIL reset_mid: got %h want %h", {a_in_ready, a_out_valid, a_out_op,
                     a_out_run_len, a_out_last, a_done, a_err, a_match, a_edit}, {1'b1, 30'b0});
        end
        rst = 1'b0;
        v0 = valid_a;
        o0 = ops_a.size();
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (valid_a != v0 || ops_a.size() != o0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_quiet: got valid_cycles=%0d ops=%0d rdy=%b want 0 0 1",
                     valid_a - v0, ops_a.size() - o0, a_in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_all_match();
        test_mixed();
        test_backpressure();
        test_run_max();
        test_lengths();
        test_both_gap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
